// File: rtl/lector_destinos_pkg.sv
// Shared definitions for the destination-FIFO reader.
// FIFO word layout (DATA_SIZE bits):
//   [DEST_BIT]          destination the classifier routed the word to
//   [CLASS_BIT]         class bit
//   [PAYLOAD_MSB:0]     payload
// State encodings are kept as plain constants so legacy code can still
// compare against them directly.
package lector_destinos_pkg;

  localparam int unsigned DATA_SIZE_DEF = 10;
  localparam int unsigned CNT_W_DEF     = 8;

  localparam int unsigned DEST_BIT    = 9;
  localparam int unsigned CLASS_BIT   = 8;
  localparam int unsigned PAYLOAD_MSB = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/buffer_salida2.sv
// Two-entry synchronous FIFO used as the output buffer of lector_destinos.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (empties the buffer)
//   push_i      write push_data_i at the tail
//   push_data_i word to write
//   pop_i       remove the head entry (ignored when empty)
//   head_o      entry 0 (the head), valid when occ_o != 0
//   occ_o       occupancy 0..2
// Push and pop in the same cycle are allowed; occupancy is then unchanged.
module buffer_salida2 #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   occ_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full buffer can only take a word if the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) e0_q <= push_data_i;
          else               e1_q <= push_data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Head leaves; the incoming word lands right behind whatever remains.
          if (occ_q == 2'd1) begin
            e0_q <= push_data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o = e0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/lector_destinos.sv
// Reader for the two destination FIFOs (D0, D1) filled by the classifier.
// Pops the FIFOs round-robin, unpacks each word and presents it on a
// valid/ready stream through a 2-entry output buffer, counts words per
// destination and flags words whose dest bit disagrees with their FIFO.
// Ports:
//   clk, reset (sync, active-high), enable (allow popping)
//   fifo_empty_d0/d1, data_d0/d1 (read data valid the cycle after pop)
//   pop_d0/pop_d1           read strobes
//   out_valid/out_ready     output handshake; out_data/out_dest/out_class fields
//   count_d0/count_d1       wrapping per-FIFO pop counters
//   err_dest                sticky routing-error flag
//   idle                    high in the IDLE state
module lector_destinos
  import lector_destinos_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [DATA_SIZE-1:0] data_d0,
  input  logic [DATA_SIZE-1:0] data_d1,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_dest,
  output logic                 out_class,
  output logic [CNT_W-1:0]     count_d0,
  output logic [CNT_W-1:0]     count_d1,
  output logic                 err_dest,
  output logic                 idle
);

  logic [1:0]           state_q, state_d;
  logic                 inflight_q;   // a pop was issued last cycle
  logic                 src_q;        // FIFO that pop came from
  logic                 pref_q;       // 0: D0 wins a tie, 1: D1 wins
  logic [CNT_W-1:0]     cnt0_q, cnt1_q;
  logic                 err_q;

  logic [1:0]           occ;
  logic [DATA_SIZE-1:0] head;
  logic [DATA_SIZE-1:0] cap_data;
  logic                 deq;
  logic [1:0]           load;
  logic                 can_pop;
  logic                 elig0, elig1;

  assign deq = (occ != 2'd0) && out_ready;

  // Entries that will occupy the buffer once this cycle's dequeue and last
  // cycle's in-flight capture settle; max is 2 - 0 + 1 = 3, fits in 2 bits.
  assign load    = occ - {1'b0, deq} + {1'b0, inflight_q};
  assign can_pop = !reset && enable && (state_q == ST_RUN) && (load < 2'd2);

  assign elig0  = !fifo_empty_d0;
  assign elig1  = !fifo_empty_d1;
  assign pop_d0 = can_pop && elig0 && (!elig1 || !pref_q);
  assign pop_d1 = can_pop && elig1 && (!elig0 || pref_q);

  assign cap_data = src_q ? data_d1 : data_d0;

  buffer_salida2 #(
    .W(DATA_SIZE)
  ) u_buf (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (inflight_q),
    .push_data_i(cap_data),
    .pop_i      (deq),
    .head_o     (head),
    .occ_o      (occ)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)                                  state_d = ST_RUN;
        else if ((occ == 2'd0) && !inflight_q)       state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      src_q      <= 1'b0;
      pref_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= pop_d0 | pop_d1;
      if (pop_d0) begin
        src_q  <= 1'b0;
        pref_q <= 1'b1;
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (pop_d1) begin
        src_q  <= 1'b1;
        pref_q <= 1'b0;
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
      if (inflight_q && (cap_data[DEST_BIT] != src_q)) err_q <= 1'b1;
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = head[PAYLOAD_MSB:0];
  assign out_dest  = head[DEST_BIT];
  assign out_class = head[CLASS_BIT];
  assign count_d0  = cnt0_q;
  assign count_d1  = cnt1_q;
  assign err_dest  = err_q;
  assign idle      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_lector_destinos.sv
module tb_lector_destinos;

  logic       clk = 1'b0;
  logic       reset, enable, fifo_empty_d0, fifo_empty_d1, out_ready;
  logic [9:0] data_d0, data_d1;
  logic       pop_d0, pop_d1, out_valid, out_dest, out_class, err_dest, idle;
  logic [7:0] out_data, count_d0, count_d1;

  lector_destinos #(.DATA_SIZE(10), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .pop_d0(pop_d0), .pop_d1(pop_d1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dest(out_dest), .out_class(out_class),
    .count_d0(count_d0), .count_d1(count_d1),
    .err_dest(err_dest), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus requested for the next cycle
  logic r_reset, r_en, r_rdy;
  // contents of the two source FIFOs
  logic [9:0] f0[$];
  logic [9:0] f1[$];

  // transaction-level reference model
  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  logic [9:0] mq[$];      // words held in the output buffer, head first
  bit         m_infl;
  bit         m_src;
  logic [9:0] m_iw;       // word popped last cycle
  mstate_t    m_state;
  bit         m_pref;     // 1: D1 has priority on a tie
  int         m_c0, m_c1;
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl = 0; m_src = 0; m_iw = '0;
    m_state = M_IDLE; m_pref = 0;
    m_c0 = 0; m_c1 = 0; m_err = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, advance model.
  task automatic cycle();
    bit deq, can, e0, e1, x0, x1;
    int load;
    mstate_t nst;
    @(negedge clk);
    reset         = r_reset;
    enable        = r_en;
    out_ready     = r_rdy;
    fifo_empty_d0 = (f0.size() == 0);
    fifo_empty_d1 = (f1.size() == 0);
    data_d0       = (m_infl && !m_src) ? m_iw : 10'($urandom);
    data_d1       = (m_infl &&  m_src) ? m_iw : 10'($urandom);
    #1;
    if (r_reset) begin
      chk("pop_in_reset", 32'({pop_d1, pop_d0}), 32'd0);
      model_reset();
      return;
    end
    deq  = (mq.size() > 0) && r_rdy;
    load = mq.size() - int'(deq) + int'(m_infl);
    can  = (m_state == M_RUN) && r_en && (load < 2);
    e0   = f0.size() > 0;
    e1   = f1.size() > 0;
    x0   = can && e0 && (!e1 || !m_pref);
    x1   = can && e1 && (!e0 || m_pref);

    chk("pop_d0", 32'(pop_d0), 32'(x0));
    chk("pop_d1", 32'(pop_d1), 32'(x1));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0)
      chk("out_word", 32'({out_dest, out_class, out_data}), 32'(mq[0]));
    chk("count_d0", 32'(count_d0), 32'(m_c0));
    chk("count_d1", 32'(count_d1), 32'(m_c1));
    chk("err_dest", 32'(err_dest), 32'(m_err));
    chk("idle", 32'(idle), 32'(m_state == M_IDLE));

    nst = m_state;
    case (m_state)
      M_IDLE:  if (r_en) nst = M_RUN;
      M_RUN:   if (!r_en) nst = M_DRAIN;
      default: if (r_en) nst = M_RUN;
               else if (mq.size() == 0 && !m_infl) nst = M_IDLE;
    endcase
    m_state = nst;

    if (deq) void'(mq.pop_front());
    if (m_infl) begin
      mq.push_back(m_iw);
      if (m_iw[9] != m_src) m_err = 1;
    end
    m_infl = x0 || x1;
    if (x0) begin
      m_iw = f0.pop_front(); m_src = 0; m_pref = 1; m_c0 = (m_c0 + 1) % 256;
    end
    if (x1) begin
      m_iw = f1.pop_front(); m_src = 1; m_pref = 0; m_c1 = (m_c1 + 1) % 256;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    fifo_empty_d0 = 1'b1; fifo_empty_d1 = 1'b1; data_d0 = '0; data_d1 = '0;
    r_reset = 1; r_en = 0; r_rdy = 1;
    model_reset();
    run(2);
    r_reset = 0;
    cycle();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_dest), 32'd0);

    // two words from D0 only
    f0 = '{10'h0A5, 10'h0B6};
    r_en = 1;
    run(8);
    chk("s1_count_d0", 32'(count_d0), 32'd2);
    chk("s1_err", 32'(err_dest), 32'd0);

    // both FIFOs loaded, alternating service
    f0 = '{10'h011, 10'h012, 10'h013};
    f1 = '{10'h221, 10'h222, 10'h223};
    run(10);
    chk("s2_drained", 32'(f0.size() + f1.size()), 32'd0);

    // backpressure: only two pops may be outstanding
    r_rdy = 0;
    f0 = '{10'h031, 10'h032, 10'h033, 10'h034};
    run(8);
    chk("s3_left", 32'(f0.size()), 32'd2);
    chk("s3_head", 32'(out_data), 32'h31);
    r_rdy = 1;
    run(8);
    chk("s3_done", 32'(f0.size()), 32'd0);

    // drop enable right after a pop; in-flight word still delivered
    f0 = '{10'h041, 10'h042, 10'h043};
    cycle();
    r_en = 0;
    run(6);
    chk("s4_idle", 32'(idle), 32'd1);
    chk("s4_left", 32'(f0.size()), 32'd2);
    f0.delete();

    // misrouted word
    r_reset = 1; cycle(); r_reset = 0;
    r_en = 1;
    f0 = '{10'h200};
    run(6);
    chk("s5_err", 32'(err_dest), 32'd1);
    f0 = '{10'h055};
    run(6);
    chk("s5_sticky", 32'(err_dest), 32'd1);

    // 256 pops from D0 wrap the counter
    r_reset = 1; cycle(); r_reset = 0;
    for (int i = 0; i < 256; i++) f0.push_back(10'(i & 8'hFF));
    run(270);
    chk("s6_wrap", 32'(count_d0), 32'd0);
    chk("s6_empty", 32'(f0.size()), 32'd0);

    // reset with two words buffered
    r_rdy = 0;
    f0 = '{10'h061, 10'h062, 10'h063, 10'h064};
    run(6);
    chk("s7_valid", 32'(out_valid), 32'd1);
    r_reset = 1; cycle(); r_reset = 0;
    cycle();
    chk("s7_valid_after", 32'(out_valid), 32'd0);
    chk("s7_count", 32'(count_d0), 32'd0);
    chk("s7_idle", 32'(idle), 32'd1);
    f0.delete();
    r_rdy = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && f0.size() < 8)
        f0.push_back({1'($urandom_range(0, 15) == 0), 9'($urandom)});
      if ($urandom_range(0, 2) == 0 && f1.size() < 8)
        f1.push_back({1'($urandom_range(0, 15) != 0), 9'($urandom)});
      r_en    = ($urandom_range(0, 9) != 0);
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    r_reset = 0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lector_destinos.md
Name: lector_destinos

Overview:
- Read-side counterpart of the classification path; drains the two destination FIFOs (D0, D1) that the classifier fills.
- Drives pop_d0/pop_d1 and arbitrates round-robin between the two FIFOs.
- Unpacks each 10-bit FIFO word and presents it on a single valid/ready output stream through a 2-entry output buffer.
- Keeps per-destination word counters and flags routing errors.

Parameters:
- DATA_SIZE, 10, FIFO word width: bit 9 = dest, bit 8 = class, bits [7:0] = payload.
- CNT_W, 8, width of the per-destination word counters.

Ports:
- clk  in  1  single clock of the block.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = may pop FIFOs; 0 = stop popping and drain the output buffer.
- fifo_empty_d0  in  1  D0 FIFO empty flag.
- fifo_empty_d1  in  1  D1 FIFO empty flag.
- data_d0  in  DATA_SIZE  D0 FIFO read data, valid the cycle after pop_d0.
- data_d1  in  DATA_SIZE  D1 FIFO read data, valid the cycle after pop_d1.
- pop_d0  out  1  read strobe to D0 FIFO.
- pop_d1  out  1  read strobe to D1 FIFO.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  8  payload.
- out_dest  out  1  dest bit of the word.
- out_class  out  1  class bit of the word.
- count_d0  out  CNT_W  words popped from D0, wraps.
- count_d1  out  CNT_W  words popped from D1, wraps.
- err_dest  out  1  sticky: a word's dest bit differed from the FIFO it came from.
- idle  out  1  state IDLE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except idle=1; state=IDLE; buffer empty; in-flight flag clear; RR pointer = D0 preferred.
- FIFO read timing: pop asserted in cycle N; data_dX is captured in cycle N+1 into the tail of the 2-entry output buffer (in-flight flag records the source).
- Pop-credit rule:
  - Pop allowed in cycle N only if occ − deq + inflight < 2.
  - occ = buffer occupancy (0..2); deq = out_valid & out_ready this cycle; inflight = pop in N−1.
  - With out_ready held 1, this sustains one word per cycle.
- Arbitration:
  - At most one pop per cycle; eligible = !fifo_empty_dX.
  - If both are eligible, pop the FIFO not served last; if one is eligible, pop it.
  - The RR pointer updates only on a pop.
  - pop_dX is never asserted while fifo_empty_dX=1.
- Output buffer:
  - FIFO order; out_valid = occ>0; head fields are driven combinationally from entry 0.
  - On deq, entry 1 shifts to entry 0.
  - Enqueue and dequeue in the same cycle is legal; occ stays unchanged.
- Counters: count_dX increments on each pop_dX and wraps 2^CNT_W−1 → 0.
- err_dest: set on capture when bit 9 ≠ source index (D0 expects 0, D1 expects 1). Sticky until reset. The word is still forwarded.
- State machine:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN: no new pops; any in-flight word is still captured; → IDLE when occ=0 and inflight=0; → RUN if enable returns to 1.
  - idle=1 only in IDLE.
- Reset asserted mid-operation: buffer contents and any in-flight word are discarded; counters clear; the same cycle's pop outputs are forced 0.

Decomposition:
- Shared package: DATA_SIZE field positions (DEST_BIT=9, CLASS_BIT=8, PAYLOAD_MSB=7), state encodings IDLE/RUN/DRAIN, and CNT_W default.
- One natural sub-module, buffer_salida2: 2-entry synchronous FIFO with occ output and same-cycle push/pop. Arbiter and FSM stay in the top level.

Test Plan:
- D0 holds 0x0A5, 0x0B6, D1 empty, enable=1, out_ready=1 → pop_d0 in 2 consecutive cycles; out_data A5 then B6, each 2 cycles after its pop; count_d0=2; err_dest=0.
- Both FIFOs hold 3 words (D0 0x011,0x012,0x013; D1 0x221,0x222,0x223) → pops alternate D0,D1,D0,… starting with D0; outputs 11,21,12,22,13,23 with out_dest 0,1,0,1,0,1; one word per cycle, no bubbles.
- out_ready=0 with D0 holding 4 words → exactly 2 pops, then pop_d0 stays 0 and out_valid=1 with the first word held. Raise out_ready → remaining 2 words popped and all 4 delivered in order.
- Drop enable one cycle after a pop → the in-flight word is still delivered; state goes DRAIN then IDLE (idle=1) once out_valid=0; no further pops.
- Word 0x200 sitting in D0 → delivered with out_dest=1 and err_dest=1; err_dest stays 1 until reset.
- Pop D0 256 times → count_d0 wraps to 0. Assert reset with 2 words buffered → next cycle out_valid=0, counts=0, idle=1, no pops.
